// File: rtl/conv_sched_if.sv
// rtl/conv_sched_if.sv - position beat stream between conv_sched and the multiplier array
interface conv_sched_if #(
   parameter int O_BITS = 4
) ();
   logic              pos_valid;
   logic              pos_ready;
   logic [O_BITS-1:0] pos_row;
   logic [O_BITS-1:0] pos_col;
   logic              pos_last;

   modport master (
      output pos_valid,
      output pos_row,
      output pos_col,
      output pos_last,
      input  pos_ready
   );

   modport slave (
      input  pos_valid,
      input  pos_row,
      input  pos_col,
      input  pos_last,
      output pos_ready
   );
endinterface

// File: rtl/conv_sched.sv
// rtl/conv_sched.sv - convolution job sequencer: kernel load, per-tile image load, scan, drain
module conv_sched #(
   parameter int K_DIM    = 3,
   parameter int I_DIM    = 8,
   parameter int PIPE_LAT = 4,
   parameter int T_BITS   = 8,
   parameter int O_DIM    = K_DIM + I_DIM - 1,
   parameter int O_BITS   = $clog2(O_DIM + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [T_BITS-1:0] cfg_tiles,
   input  logic              abort,
   output logic              kern_req,
   input  logic              kern_valid,
   output logic              img_req,
   input  logic              img_valid,
   conv_sched_if.master      pos,
   output logic [T_BITS-1:0] tile_idx,
   output logic              busy,
   output logic              done
);

   localparam int D_BITS = (PIPE_LAT < 2) ? 1 : $clog2(PIPE_LAT + 1);
   localparam logic [D_BITS-1:0] D_INIT = D_BITS'(PIPE_LAT);
   localparam logic [O_BITS-1:0] O_MAX  = O_BITS'(O_DIM - 1);
   localparam logic [O_BITS-1:0] O_PEN  = O_BITS'(O_DIM - 2);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WAIT_K = 3'd1,
      WAIT_I = 3'd2,
      SCAN   = 3'd3,
      DRAIN  = 3'd4,
      DONE   = 3'd5
   } state_t;

   state_t            state;
   logic [T_BITS-1:0] tiles;
   logic [D_BITS-1:0] drain_cnt;
   logic [T_BITS:0]   tile_nxt;

   // one extra bit so tile_idx = 2^T_BITS-1 cannot wrap the "more tiles" compare
   assign tile_nxt = {1'b0, tile_idx} + 1'b1;

   // sequencer; every output is a register updated alongside the state it belongs to
   always_ff @(posedge clk) begin
      if (rst || (abort && state != IDLE)) begin
         state         <= IDLE;
         tiles         <= '0;
         drain_cnt     <= '0;
         tile_idx      <= '0;
         kern_req      <= 1'b0;
         img_req       <= 1'b0;
         pos.pos_valid <= 1'b0;
         pos.pos_row   <= '0;
         pos.pos_col   <= '0;
         pos.pos_last  <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // abort in IDLE has nothing to cancel but still vetoes a coincident start
               if (start && !abort) begin
                  state    <= WAIT_K;
                  tiles    <= (cfg_tiles == '0) ? T_BITS'(1) : cfg_tiles;
                  tile_idx <= '0;
                  kern_req <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            WAIT_K: begin
               if (kern_valid) begin
                  state    <= WAIT_I;
                  kern_req <= 1'b0;
                  img_req  <= 1'b1;
               end
            end
            WAIT_I: begin
               if (img_valid) begin
                  state         <= SCAN;
                  img_req       <= 1'b0;
                  pos.pos_valid <= 1'b1;
                  pos.pos_row   <= '0;
                  pos.pos_col   <= '0;
                  pos.pos_last  <= (O_DIM == 1);
               end
            end
            SCAN: begin
               if (pos.pos_ready) begin
                  if (pos.pos_last) begin
                     state         <= DRAIN;
                     drain_cnt     <= D_INIT;
                     pos.pos_valid <= 1'b0;
                     pos.pos_last  <= 1'b0;
                     pos.pos_row   <= '0;
                     pos.pos_col   <= '0;
                  end else if (pos.pos_col == O_MAX) begin
                     pos.pos_col  <= '0;
                     pos.pos_row  <= pos.pos_row + 1'b1;
                     pos.pos_last <= 1'b0;
                  end else begin
                     pos.pos_col  <= pos.pos_col + 1'b1;
                     pos.pos_last <= (pos.pos_row == O_MAX) && (pos.pos_col == O_PEN);
                  end
               end
            end
            DRAIN: begin
               // leaves on the cycle the counter would reach zero: PIPE_LAT cycles in DRAIN
               if (drain_cnt <= D_BITS'(1)) begin
                  drain_cnt <= '0;
                  if (tile_nxt < {1'b0, tiles}) begin
                     state    <= WAIT_I;
                     tile_idx <= tile_idx + 1'b1;
                     img_req  <= 1'b1;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end else begin
                  drain_cnt <= drain_cnt - 1'b1;
               end
            end
            DONE: begin
               state    <= IDLE;
               done     <= 1'b0;
               busy     <= 1'b0;
               tile_idx <= '0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_conv_sched.sv
// tb/tb_conv_sched.sv - randomized self-checking bench for conv_sched against a job-level model
module tb_conv_sched;

   localparam int PIPE_LAT = 4;
   localparam int O_DIM    = 10;
   localparam int O_BITS   = 4;
   localparam int T_BITS   = 8;
   localparam int BUDGET   = 5000;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [T_BITS-1:0] cfg_tiles;
   logic              abort;
   logic              kern_req;
   logic              kern_valid;
   logic              img_req;
   logic              img_valid;
   logic [T_BITS-1:0] tile_idx;
   logic              busy;
   logic              done;

   conv_sched_if #(.O_BITS(O_BITS)) pif ();

   logic              pos_valid;
   logic [O_BITS-1:0] pos_row;
   logic [O_BITS-1:0] pos_col;
   logic              pos_last;
   assign pos_valid = pif.pos_valid;
   assign pos_row   = pif.pos_row;
   assign pos_col   = pif.pos_col;
   assign pos_last  = pif.pos_last;

   conv_sched #(
      .K_DIM   (3),
      .I_DIM   (8),
      .PIPE_LAT(PIPE_LAT),
      .T_BITS  (T_BITS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .cfg_tiles (cfg_tiles),
      .abort     (abort),
      .kern_req  (kern_req),
      .kern_valid(kern_valid),
      .img_req   (img_req),
      .img_valid (img_valid),
      .pos       (pif.master),
      .tile_idx  (tile_idx),
      .busy      (busy),
      .done      (done)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pk(input int t, input int r, input int c, input bit l);
      return 32'((t << 16) | (r << 8) | (c << 2) | int'(l));
   endfunction

   // job statistics gathered by the monitor
   logic [31:0] beats[$];
   int beats_per_tile[256];
   int cyc = 0;
   int last_cyc;
   int done_cnt;
   int img_rises;
   int kern_cyc;
   int img_cyc;
   bit prev_stall = 0;
   bit prev_abort = 0;
   bit prev_img_req = 0;
   logic [31:0] prev_pos = '0;

   // stimulus knobs for the current job
   int rdy_mode;
   int kd;
   int id;
   bit kv_hold;
   int abort_beat;
   int rst_row;
   int mid_start;
   bit fired;
   int job_cyc;
   int kcnt;
   int icnt;

   // mid-cycle monitor: records accepted beats and checks stall stability and drain spacing
   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         if (prev_stall && !prev_abort) begin
            check("stall_valid", pos_valid, 1);
            check("stall_pos", pk(0, int'(pos_row), int'(pos_col), pos_last), prev_pos);
         end
         if (pos_valid && pif.pos_ready) begin
            beats.push_back(pk(int'(tile_idx), int'(pos_row), int'(pos_col), pos_last));
            beats_per_tile[tile_idx]++;
            if (pos_last) last_cyc = cyc;
         end
         if (done) begin
            done_cnt++;
            check("done_latency", cyc - last_cyc, PIPE_LAT + 1);
         end
         if (img_req && !prev_img_req) begin
            img_rises++;
            if (tile_idx != 0) check("drain_gap", cyc - last_cyc, PIPE_LAT + 1);
         end
         kern_cyc += int'(kern_req);
         img_cyc  += int'(img_req);
      end
      prev_stall   = pos_valid && !pif.pos_ready;
      prev_abort   = abort || rst;
      prev_pos     = pk(0, int'(pos_row), int'(pos_col), pos_last);
      prev_img_req = img_req;
   end

   // one clock: let the edge happen, then play kernel/image controller and multiplier array
   task automatic step();
      bit img_hs;
      img_hs = img_req && img_valid;
      @(posedge clk);
      #1;
      job_cyc++;
      if (img_hs) check("first_beat", pos_valid, 1);
      start = 1'b0;
      abort = 1'b0;
      rst   = 1'b0;
      if (kv_hold) begin
         kern_valid = 1'b1;
      end else if (kern_req) begin
         kcnt++;
         kern_valid = (kcnt > kd);
      end else begin
         kcnt = 0;
         kern_valid = 1'b0;
      end
      if (img_req) begin
         icnt++;
         img_valid = (icnt > id);
      end else begin
         icnt = 0;
         img_valid = 1'b0;
      end
      pif.pos_ready = (rdy_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (job_cyc == mid_start) begin
         start = 1'b1;
         cfg_tiles = T_BITS'(1);
      end
      if (abort_beat > 0 && pos_valid && tile_idx == 1 && beats_per_tile[1] == abort_beat - 1) begin
         abort = 1'b1;
         pif.pos_ready = 1'b0;
         abort_beat = 0;
         fired = 1;
      end
      if (rst_row >= 0 && pos_valid && int'(pos_row) == rst_row) begin
         rst = 1'b1;
         rst_row = -1;
         fired = 1;
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_kern_req"}, kern_req, 0);
      check({tag, "_img_req"}, img_req, 0);
      check({tag, "_pos_valid"}, pos_valid, 0);
      check({tag, "_pos_row"}, pos_row, 0);
      check({tag, "_pos_col"}, pos_col, 0);
      check({tag, "_pos_last"}, pos_last, 0);
      check({tag, "_tile_idx"}, tile_idx, 0);
      check({tag, "_done"}, done, 0);
   endtask

   task automatic run_job(input int tiles, input int rdy, input int kdl, input int idl,
                          input bit hold, input int ab_beat, input int rrow, input int mstart);
      int ntile;
      int steps;
      bit was_abort;
      logic [31:0] exp_q[$];
      ntile      = (tiles == 0) ? 1 : tiles;
      rdy_mode   = rdy;
      kd         = kdl;
      id         = idl;
      kv_hold    = hold;
      abort_beat = ab_beat;
      rst_row    = rrow;
      mid_start  = mstart;
      was_abort  = (ab_beat > 0);
      fired      = 0;
      beats.delete();
      for (int i = 0; i < 256; i++) beats_per_tile[i] = 0;
      done_cnt  = 0;
      img_rises = 0;
      kern_cyc  = 0;
      img_cyc   = 0;
      last_cyc  = -1000;
      job_cyc   = 0;
      kcnt      = 0;
      icnt      = 0;
      kern_valid = hold;
      pif.pos_ready = 1'b1;
      start     = 1'b1;
      cfg_tiles = T_BITS'(tiles);
      step();
      check("start_kern_req", kern_req, 1);
      check("start_busy", busy, 1);
      check("start_tile_idx", tile_idx, 0);
      steps = 0;
      while (busy && steps < BUDGET && !fired) begin
         step();
         steps++;
      end
      if (fired) begin
         step();
         check_idle(was_abort ? "abort" : "rst");
         if (was_abort) begin
            check("abort_beats", beats.size(), O_DIM * O_DIM + ab_beat - 1);
            repeat (PIPE_LAT + 4) step();
            check("abort_no_done", done_cnt, 0);
         end
         kv_hold = 0;
         return;
      end
      check("job_finished", busy, 0);
      check("end_tile_idx", tile_idx, 0);
      check("done_pulses", done_cnt, 1);
      check("img_req_rises", img_rises, ntile);
      check("img_req_cycles", img_cyc, ntile * (id + 1));
      check("kern_req_cycles", kern_cyc, hold ? 1 : kd + 1);
      for (int t = 0; t < ntile; t++)
         for (int r = 0; r < O_DIM; r++)
            for (int c = 0; c < O_DIM; c++)
               exp_q.push_back(pk(t, r, c, (r == O_DIM - 1) && (c == O_DIM - 1)));
      check("beat_count", beats.size(), exp_q.size());
      for (int i = 0; i < beats.size() && i < exp_q.size(); i++)
         check("beat", beats[i], exp_q[i]);
      kv_hold = 0;
      step();
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      cfg_tiles = '0;
      kern_valid = 1'b0;
      img_valid = 1'b0;
      pif.pos_ready = 1'b0;
      rdy_mode = 0; kd = 0; id = 0; kv_hold = 0;
      abort_beat = 0; rst_row = -1; mid_start = -1; fired = 0;
      job_cyc = 0; kcnt = 0; icnt = 0;
      repeat (3) @(posedge clk);
      #1;
      check_idle("reset");
      rst = 1'b0;
      step();

      // reset mid-scan, then a clean job
      run_job(2, 0, 1, 1, 0, 0, 3, -1);
      run_job(1, 0, 0, 0, 0, 0, -1, -1);
      // single tile, handshakes arriving after 2 cycles
      run_job(1, 0, 2, 2, 0, 0, -1, -1);
      // three tiles with a start pulse and cfg_tiles change mid-job
      run_job(3, 0, 1, 0, 0, 0, -1, 150);
      // random backpressure
      run_job(2, 1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0, 0, -1, -1);
      // abort at beat 57 of tile 1
      run_job(3, 0, 0, 0, 0, 57, -1, -1);
      // abort and start together in IDLE
      abort = 1'b1;
      start = 1'b1;
      cfg_tiles = T_BITS'(2);
      step();
      check("abort_start_busy", busy, 0);
      check("abort_start_kern_req", kern_req, 0);
      // zero tiles behaves as one; kernel already present before start
      run_job(0, 0, 0, 0, 1, 0, -1, -1);
      // a few fully random jobs
      for (int j = 0; j < 3; j++)
         run_job(int'($urandom_range(1, 3)), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 0, -1, int'($urandom_range(20, 200)));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
